// File: rtl/counter_sequencer_pkg.sv
// Shared encodings for the counter sequencer:
// operation/control codes and FSM states.
package counter_sequencer_pkg;

  localparam logic [1:0] OP_CLEAR = 2'd0;
  localparam logic [1:0] OP_ADD1  = 2'd1;
  localparam logic [1:0] OP_ADD2  = 2'd2;
  localparam logic [1:0] OP_SUB1  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] steps;
  } cmd_t;

endpackage

// File: rtl/counter_sequencer_if.sv
// Request/grant and status bundle between the
// two requesters and the counter sequencer.
interface counter_sequencer_if;

  logic [1:0] Req;
  logic [1:0] Op0;
  logic [1:0] Op1;
  logic [3:0] Steps0;
  logic [3:0] Steps1;
  logic [1:0] Grant;
  logic [1:0] Done;
  logic [1:0] Control;
  logic [3:0] Count;
  logic       Busy;

  modport master (
    output Req, Op0, Op1, Steps0, Steps1,
    input  Grant, Done, Control, Count, Busy
  );

  modport slave (
    input  Req, Op0, Op1, Steps0, Steps1,
    output Grant, Done, Control, Count, Busy
  );

endinterface

// File: rtl/counter_sequencer_mod_step.sv
// Combinational next-count logic: applies one
// operation to the count, wrapping at MODULUS.
module mod_step
  import counter_sequencer_pkg::*;
#(
  parameter int MODULUS = 9
) (
  input  logic [3:0] count,
  input  logic [1:0] op,
  output logic [3:0] count_nxt
);

  localparam logic [3:0] MAX = 4'(MODULUS - 1);
  localparam logic [4:0] MOD = 5'(MODULUS);

  logic [4:0] sum2;
  assign sum2 = {1'b0, count} + 5'd2;

  // Select the wrapped result for the applied op
  always_comb begin
    count_nxt = count;
    unique case (op)
      OP_CLEAR: count_nxt = 4'd0;
      OP_ADD1:  count_nxt = (count == MAX) ? 4'd0
                                           : count + 4'd1;
      OP_ADD2:  count_nxt = (sum2 >= MOD) ? 4'(sum2 - MOD)
                                          : sum2[3:0];
      OP_SUB1:  count_nxt = (count == 4'd0) ? MAX
                                            : count - 4'd1;
      default:  count_nxt = count;
    endcase
  end

endmodule

// File: rtl/counter_sequencer.sv
// Two-requester round-robin sequencer that runs a
// latched op for Steps cycles on a modulo counter.
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int MODULUS = 9
) (
  input  logic                Clock,
  input  logic                Reset,
  counter_sequencer_if.slave  bus
);

  state_t     state, state_nxt;
  cmd_t       cmd;
  logic [3:0] rem;
  logic [3:0] count, count_nxt;
  logic [1:0] grant;
  logic       last;
  logic       any;
  logic       win;
  cmd_t       win_cmd;

  mod_step #(.MODULUS(MODULUS)) u_step (
    .count     (count),
    .op        (cmd.op),
    .count_nxt (count_nxt)
  );

  // Round-robin pick: on a tie the one not granted last wins
  always_comb begin
    any = |bus.Req;
    win = bus.Req[1];
    if (bus.Req == 2'b11) win = ~last;
    win_cmd = win ? '{op: bus.Op1, steps: bus.Steps1}
                  : '{op: bus.Op0, steps: bus.Steps0};
  end

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and per-state outputs
  always_comb begin
    state_nxt   = state;
    bus.Control = 2'd0;
    bus.Done    = 2'd0;
    bus.Busy    = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (any)
          state_nxt = (win_cmd.steps != 4'd0) ? RUN : DONE;
      end
      RUN: begin
        bus.Control = cmd.op;
        if (rem == 4'd1) state_nxt = DONE;
      end
      DONE: begin
        bus.Done  = grant;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant, pointer, latched command, step counter, count
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      grant <= 2'b00;
      last  <= 1'b1;
      cmd   <= '0;
      rem   <= 4'd0;
      count <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            grant <= win ? 2'b10 : 2'b01;
            last  <= win;
            cmd   <= win_cmd;
            rem   <= win_cmd.steps;
          end
        end
        RUN: begin
          count <= count_nxt;
          rem   <= rem - 4'd1;
        end
        DONE: grant <= 2'b00;
        default: grant <= 2'b00;
      endcase
    end
  end

  assign bus.Grant = grant;
  assign bus.Count = count;

endmodule
